// File: rtl/sseg_scan_if.sv
// sseg_scan_if
//   Bundles the load/value side and the display-drive side of the scan
//   controller into one interface.
//
//   Handshake (load): load is a 1-cycle strobe qualified only by itself.
//   On any rising clock edge with load=1, value/dp_in are captured into the
//   pending buffer. The controller has no ready signal and never stalls, so
//   every strobe is taken. Back-to-back strobes overwrite each other and the
//   last one wins.
//
//   Signals
//     load           master->slave  capture strobe
//     value[15:0]    master->slave  four hex nibbles, [3:0] = rightmost digit
//     dp_in[3:0]     master->slave  decimal point per digit, 1 = lit
//     blank_lz       master->slave  leading-zero blanking enable (level)
//     digit[3:0]     slave->master  nibble for the shared segment decoder
//     dp             slave->master  decimal point for the decoder
//     an[3:0]        slave->master  active-low anodes
//     frame_tick     slave->master  pulse on the last cycle of slot 3
//     update_pending slave->master  pending buffer not yet displayed
//     state_dbg      slave->master  scan FSM state (0 = BLANK, 1 = DRIVE)
interface sseg_scan_if;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [3:0]  digit;
  logic        dp;
  logic [3:0]  an;
  logic        frame_tick;
  logic        update_pending;
  logic        state_dbg;

  modport master (
    output load, value, dp_in, blank_lz,
    input  digit, dp, an, frame_tick, update_pending, state_dbg
  );

  modport slave (
    input  load, value, dp_in, blank_lz,
    output digit, dp, an, frame_tick, update_pending, state_dbg
  );
endinterface

// File: rtl/sseg_scan_ctrl.sv
// sseg_scan_ctrl
//   Time-multiplexed scan controller for a 4-digit common-anode 7-segment
//   display. One shared segment decoder is fed digit/dp for the digit
//   currently being scanned, while the active-low anodes select which digit
//   is lit. Each digit slot lasts CLK_DIV cycles. The first BLANK_CYCLES
//   cycles of a slot keep every anode off so the decoder output has settled
//   before the next digit lights, which suppresses ghosting.
//
//   The displayed value is double-buffered. A load captures into a pending
//   buffer, and the pending buffer is copied to the display buffer only on the
//   last cycle of a frame, so a frame never shows a mix of old and new digits.
//
//   Parameters
//     CLK_DIV       cycles per digit slot
//     BLANK_CYCLES  all-off cycles at the start of each slot (1..CLK_DIV-1)
//
//   Ports
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    sseg_scan_if.slave (load/value/dp_in/blank_lz in,
//            digit/dp/an/frame_tick/update_pending/state_dbg out)
module sseg_scan_ctrl #(
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  sseg_scan_if.slave  bus
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_CNT = CNT_W'(BLANK_CYCLES);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_e;

  // Scan position and FSM state
  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  state_e           state;

  // Double buffer
  logic [15:0]      disp_val;
  logic [3:0]       disp_dp;
  logic [15:0]      pend_val;
  logic [3:0]       pend_dp;
  logic             upd_pend;

  // Registered outputs
  logic [3:0]       digit_q;
  logic             dp_q;
  logic [3:0]       an_q;
  logic             tick_q;

  // Next-cycle values. The outputs are registered, so they are computed from
  // where the scan will be after this edge, not from where it is now. This
  // keeps an/digit/dp aligned with cnt/idx on the same cycle.
  logic             slot_end;
  logic             frame_end;
  logic             commit;
  logic [CNT_W-1:0] cnt_nxt;
  logic [1:0]       idx_nxt;
  logic [15:0]      disp_val_nxt;
  logic [3:0]       disp_dp_nxt;
  logic [3:0]       lz_mask;
  logic [3:0]       nib_nxt;
  logic             blanked_nxt;
  logic             drive_nxt;
  state_e           state_nxt;
  logic [3:0]       an_nxt;

  always_comb begin
    slot_end  = 1'b0;
    frame_end = 1'b0;
    commit    = 1'b0;
    cnt_nxt   = cnt;
    idx_nxt   = idx;

    slot_end  = (cnt == LAST_CNT);
    frame_end = slot_end && (idx == 2'd3);
    // A load landing on the same edge does not disturb this commit. The old
    // pending contents go to the display, and the new load stays pending.
    commit    = frame_end && upd_pend;

    if (slot_end) begin
      cnt_nxt = '0;
      idx_nxt = idx + 2'd1;
    end else begin
      cnt_nxt = cnt + CNT_W'(1);
      idx_nxt = idx;
    end
  end

  always_comb begin
    disp_val_nxt = disp_val;
    disp_dp_nxt  = disp_dp;
    if (commit) begin
      disp_val_nxt = pend_val;
      disp_dp_nxt  = pend_dp;
    end
  end

  // Leading-zero mask. Digit i is a leading zero when nibbles i..3 are all
  // zero. Digit 0 is always shown, so a value of zero still displays "0".
  always_comb begin
    lz_mask    = 4'b0000;
    lz_mask[3] = (disp_val_nxt[15:12] == 4'h0);
    lz_mask[2] = lz_mask[3] && (disp_val_nxt[11:8] == 4'h0);
    lz_mask[1] = lz_mask[2] && (disp_val_nxt[7:4]  == 4'h0);
    lz_mask[0] = 1'b0;
  end

  always_comb begin
    nib_nxt     = disp_val_nxt[{idx_nxt, 2'b00} +: 4];
    blanked_nxt = bus.blank_lz && lz_mask[idx_nxt];
    drive_nxt   = (cnt_nxt >= BLANK_CNT);
    state_nxt   = drive_nxt ? ST_DRIVE : ST_BLANK;
    an_nxt      = 4'b1111;
    if (drive_nxt && !blanked_nxt) begin
      an_nxt = ~(4'b0001 << idx_nxt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      idx      <= 2'd0;
      state    <= ST_BLANK;
      disp_val <= 16'h0000;
      disp_dp  <= 4'b0000;
      pend_val <= 16'h0000;
      pend_dp  <= 4'b0000;
      upd_pend <= 1'b0;
      digit_q  <= 4'h0;
      dp_q     <= 1'b0;
      an_q     <= 4'b1111;
      tick_q   <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      idx      <= idx_nxt;
      disp_val <= disp_val_nxt;
      disp_dp  <= disp_dp_nxt;

      // Pending buffer and its flag. A load always wins over clearing the
      // flag, so a value loaded on the commit edge is shown next frame.
      if (bus.load) begin
        pend_val <= bus.value;
        pend_dp  <= bus.dp_in;
        upd_pend <= 1'b1;
      end else if (commit) begin
        upd_pend <= 1'b0;
      end

      // digit/dp only change when a new slot begins. That is the first BLANK
      // cycle, which gives the decoder the whole blank window to settle.
      // A blanked digit also hides its decimal point.
      if (slot_end) begin
        digit_q <= nib_nxt;
        dp_q    <= disp_dp_nxt[idx_nxt] && !blanked_nxt;
      end

      case (state)
        ST_BLANK: state <= state_nxt;
        ST_DRIVE: state <= state_nxt;
        default:  state <= ST_BLANK;
      endcase

      an_q   <= an_nxt;
      tick_q <= (idx_nxt == 2'd3) && (cnt_nxt == LAST_CNT);
    end
  end

  assign bus.digit          = digit_q;
  assign bus.dp             = dp_q;
  assign bus.an             = an_q;
  assign bus.frame_tick     = tick_q;
  assign bus.update_pending = upd_pend;
  assign bus.state_dbg      = state;

endmodule
